picorv32_mem_responder: RTL

- Memory-side responder for the picorv32 native memory interface: accepts mem_valid requests from the core and returns mem_ready/mem_rdata from an internal word RAM.
- Response latency per transaction is set by a fuzz-driven input, so the core sees varied wait states.
- Provides a backdoor preload port, out-of-range error reporting and fetch/read/write counters for coverage.
- Sits beside the core in the fuzz harness and drives the core's c_mem_ready/c_mem_rdata inputs.

---
 rtl/picorv32_mem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/picorv32_mem_responder.sv
// Word-RAM responder for the picorv32 native memory bus with fuzz-controlled wait states.
// Ready comes 1+latency cycles after accept, then a one-cycle gap before the next accept.
module picorv32_mem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LAT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [31:0]           mem_rdata,
  input  logic [LAT_WIDTH-1:0]  latency,
  input  logic                  init_we,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [31:0]           init_data,
  output logic                  init_drop,
  output logic                  err,
  output logic [15:0]           fetch_cnt,
  output logic [15:0]           read_cnt,
  output logic [15:0]           write_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

  state_t                state_q, state_d;
  logic [LAT_WIDTH-1:0]  lat_q, lat_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  instr_q, instr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  init_drop_q, init_drop_d;
  logic [15:0]           fetch_cnt_q, fetch_cnt_d;
  logic [15:0]           read_cnt_q, read_cnt_d;
  logic [15:0]           write_cnt_q, write_cnt_d;

  logic [31:0]           ram [DEPTH];
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  is_rd;
  logic                  bus_we;
  logic                  init_ok;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    fetch_cnt_d = fetch_cnt_q;
    read_cnt_d  = read_cnt_q;
    write_cnt_d = write_cnt_q;

    off      = addr_q - BASE_ADDR;
    in_range = (addr_q >= BASE_ADDR) && ((off >> (ADDR_WIDTH + 2)) == 32'd0);
    idx      = off[ADDR_WIDTH+1:2];
    is_rd    = (wstrb_q == 4'b0000);
    // A write caught by reset in its RESP cycle never reaches the RAM.
    bus_we   = (state_q == S_RESP) && !is_rd && in_range && !reset;
    init_ok  = init_we && !(bus_we && (init_addr == idx));
    init_drop_d = init_we && !init_ok;

    unique case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          lat_d   = latency;
          state_d = (latency == '0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_WIDTH'(1)) state_d = S_RESP;
        else                        lat_d   = lat_q - LAT_WIDTH'(1);
      end
      S_RESP: begin
        state_d = S_GAP;
        if (is_rd) begin
          rdata_d = in_range ? ram[idx] : 32'h0;
          if (instr_q) fetch_cnt_d = sat_inc(fetch_cnt_q);
          else         read_cnt_d  = sat_inc(read_cnt_q);
        end else begin
          write_cnt_d = sat_inc(write_cnt_q);
        end
        if (!in_range) err_d = 1'b1;
      end
      S_GAP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      instr_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      init_drop_q <= 1'b0;
      fetch_cnt_q <= '0;
      read_cnt_q  <= '0;
      write_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      init_drop_q <= init_drop_d;
      fetch_cnt_q <= fetch_cnt_d;
      read_cnt_q  <= read_cnt_d;
      write_cnt_q <= write_cnt_d;
    end
  end

  // RAM is not reset so preloaded contents survive a core reset.
  always_ff @(posedge clk) begin
    if (init_ok) ram[init_addr] <= init_data;
    if (bus_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) ram[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign mem_ready = (state_q == S_RESP);
  assign mem_rdata = rdata_d;
  assign init_drop = init_drop_q;
  assign err       = err_q;
  assign fetch_cnt = fetch_cnt_q;
  assign read_cnt  = read_cnt_q;
  assign write_cnt = write_cnt_q;

endmodule
